// File: rtl/id_resp_queue_bank.sv
// Per-ID response queue bank: steers ID-tagged beats into per-ID FIFOs, pops by ID.
// Latency 1 (enqueue to poppable, no bypass); illegal IDs sunk; full queue deasserts enq_ready. Error outputs under `ID_QUEUE_ERR_EN.
module id_resp_queue_bank #(
    parameter int NUM_IDS = 2,
    parameter int ID_W    = 4,
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enq_valid,
    output logic                enq_ready,
    input  logic [ID_W-1:0]     enq_id,
    input  logic [DATA_W-1:0]   enq_data,
    input  logic                deq_req,
    input  logic [ID_W-1:0]     deq_id,
    output logic                deq_valid,
    output logic [DATA_W-1:0]   deq_data,
    output logic [NUM_IDS-1:0]  q_nonempty,
    output logic [NUM_IDS-1:0]  q_full
`ifdef ID_QUEUE_ERR_EN
    ,
    output logic                err_sticky,
    output logic [1:0]          err_cause
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1;

    logic [DATA_W-1:0] mem_q [NUM_IDS][DEPTH];
    logic [DATA_W-1:0] mem_d [NUM_IDS][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_IDS];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_IDS];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_IDS];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_IDS];
    logic [CNT_W-1:0]  count_q  [NUM_IDS];
    logic [CNT_W-1:0]  count_d  [NUM_IDS];
    logic [NUM_IDS-1:0] nonempty_q, nonempty_d;
    logic [NUM_IDS-1:0] full_q, full_d;
    logic [NUM_IDS-1:0] push, pop;

    logic             enq_legal, deq_legal;
    logic [IDX_W-1:0] enq_idx, deq_idx;

    assign enq_legal = int'(enq_id) < NUM_IDS;
    assign deq_legal = int'(deq_id) < NUM_IDS;
    assign enq_idx   = enq_id[IDX_W-1:0];
    assign deq_idx   = deq_id[IDX_W-1:0];

    // Illegal IDs are always accepted so a bad producer can never wedge the channel.
    assign enq_ready  = enq_legal ? ~full_q[enq_idx] : 1'b1;
    assign deq_valid  = deq_legal & nonempty_q[deq_idx];
    assign q_nonempty = nonempty_q;
    assign q_full     = full_q;

    always_comb begin
        deq_data = '0;
        if (deq_valid) begin
            deq_data = mem_q[deq_idx][rd_ptr_q[deq_idx]];
        end
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        nonempty_d = nonempty_q;
        full_d     = full_q;
        push       = '0;
        pop        = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            // Push uses the registered full flag: a same-cycle pop does not free a slot.
            push[i] = enq_valid & enq_legal & (enq_idx == IDX_W'(i)) & ~full_q[i];
            pop[i]  = deq_req & deq_valid & (deq_idx == IDX_W'(i));
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = enq_data;
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
            nonempty_d[i] = count_d[i] != '0;
            full_d[i]     = count_d[i] == CNT_W'(DEPTH);
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            nonempty_q <= '0;
            full_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            nonempty_q <= nonempty_d;
            full_q     <= full_d;
        end
    end

`ifdef ID_QUEUE_ERR_EN
    logic [1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (enq_valid & ~enq_legal) begin
            err_d[0] = 1'b1;
        end
        if (deq_req & ~deq_valid) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cause  = err_q;
    assign err_sticky = |err_q;
`endif

endmodule
